// File: rtl/dps_sci_arbiter.sv
// dps_sci_arbiter
//   Shares the single SCI register port between two CPU-side masters.
//   Each master owns a one-entry request slot; pending slots are issued to
//   the SCI one per cycle, round-robin (or fixed M0-first when
//   P_RR_ENABLE = 0). Read data is registered and returned only to the
//   master that issued the read.
//
// Ports
//   iIF_CLOCK, inRESET           clock, asynchronous active-low reset
//   iMx_REQ_VALID/RW/ADDR/DATA   master x request (x = 0, 1)
//   oMx_REQ_BUSY                 master x slot occupied, request ignored
//   oMx_REQ_VALID/DATA           master x read response (1-cycle pulse)
//   oSCI_REQ_VALID/RW/ADDR/DATA  issue to SCI
//   iSCI_REQ_BUSY                SCI stall, issue held
//   iSCI_REQ_VALID/DATA          same-cycle read data from SCI
module dps_sci_arbiter #(
    parameter bit P_RR_ENABLE = 1'b1
) (
    input  logic        iIF_CLOCK,
    input  logic        inRESET,
    input  logic        iM0_REQ_VALID,
    output logic        oM0_REQ_BUSY,
    input  logic        iM0_REQ_RW,
    input  logic [1:0]  iM0_REQ_ADDR,
    input  logic [31:0] iM0_REQ_DATA,
    output logic        oM0_REQ_VALID,
    output logic [31:0] oM0_REQ_DATA,
    input  logic        iM1_REQ_VALID,
    output logic        oM1_REQ_BUSY,
    input  logic        iM1_REQ_RW,
    input  logic [1:0]  iM1_REQ_ADDR,
    input  logic [31:0] iM1_REQ_DATA,
    output logic        oM1_REQ_VALID,
    output logic [31:0] oM1_REQ_DATA,
    output logic        oSCI_REQ_VALID,
    input  logic        iSCI_REQ_BUSY,
    output logic        oSCI_REQ_RW,
    output logic [1:0]  oSCI_REQ_ADDR,
    output logic [31:0] oSCI_REQ_DATA,
    input  logic        iSCI_REQ_VALID,
    input  logic [31:0] iSCI_REQ_DATA
);

    typedef enum logic {
        PTR_M0 = 1'b0,
        PTR_M1 = 1'b1
    } ptr_e;

    // Per-master views of the request inputs
    logic [1:0]       req_valid;
    logic [1:0]       req_rw;
    logic [1:0][1:0]  req_addr;
    logic [1:0][31:0] req_data;

    assign req_valid = {iM1_REQ_VALID, iM0_REQ_VALID};
    assign req_rw    = {iM1_REQ_RW,    iM0_REQ_RW};
    assign req_addr  = {iM1_REQ_ADDR,  iM0_REQ_ADDR};
    assign req_data  = {iM1_REQ_DATA,  iM0_REQ_DATA};

    // Slot and response state
    logic [1:0]       pend_q,      pend_d;
    logic [1:0]       rw_q,        rw_d;
    logic [1:0][1:0]  addr_q,      addr_d;
    logic [1:0][31:0] data_q,      data_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0][31:0] rsp_data_q,  rsp_data_d;
    ptr_e             ptr_q,       ptr_d;

    logic grant_vld;
    logic grant_idx;
    logic issue;

    always_comb begin
        grant_vld = |pend_q;
        // Contention goes to the pointer's master; otherwise the only
        // pending slot wins (index 0 when nothing is pending, masked below).
        if (pend_q == 2'b11) begin
            grant_idx = P_RR_ENABLE && (ptr_q == PTR_M1);
        end else begin
            grant_idx = pend_q[1];
        end
        issue = grant_vld && !iSCI_REQ_BUSY;
    end

    always_comb begin
        pend_d      = pend_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        ptr_d       = ptr_q;

        if (issue) begin
            pend_d[grant_idx] = 1'b0;
            if (P_RR_ENABLE) begin
                ptr_d = grant_idx ? PTR_M0 : PTR_M1;
            end
            if (!rw_q[grant_idx]) begin
                rsp_valid_d[grant_idx] = 1'b1;
                rsp_data_d[grant_idx]  = iSCI_REQ_VALID ? iSCI_REQ_DATA : '0;
            end
        end

        // Accept only into a slot that was empty this cycle; an issued slot
        // reports busy until the following cycle, so no conflict with issue.
        for (int unsigned m = 0; m < 2; m++) begin
            if (req_valid[m] && !pend_q[m]) begin
                pend_d[m] = 1'b1;
                rw_d[m]   = req_rw[m];
                addr_d[m] = req_addr[m];
                data_d[m] = req_data[m];
            end
        end
    end

    always_ff @(posedge iIF_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            pend_q      <= '0;
            rw_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            ptr_q       <= PTR_M0;
        end else begin
            pend_q      <= pend_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ptr_q       <= ptr_d;
        end
    end

    assign oM0_REQ_BUSY   = pend_q[0];
    assign oM1_REQ_BUSY   = pend_q[1];
    assign oM0_REQ_VALID  = rsp_valid_q[0];
    assign oM1_REQ_VALID  = rsp_valid_q[1];
    assign oM0_REQ_DATA   = rsp_data_q[0];
    assign oM1_REQ_DATA   = rsp_data_q[1];

    assign oSCI_REQ_VALID = issue;
    assign oSCI_REQ_RW    = grant_vld ? rw_q[grant_idx]   : 1'b0;
    assign oSCI_REQ_ADDR  = grant_vld ? addr_q[grant_idx] : 2'b00;
    assign oSCI_REQ_DATA  = grant_vld ? data_q[grant_idx] : 32'h0;

endmodule

// File: doc/dps_sci_arbiter.md
Name: dps_sci_arbiter

Overview:
- Two-master arbiter that shares the single SCI register port (TX / RX / CFG) between two CPU-side requesters, e.g. the main core and a debug agent.
- Each master gets a one-entry request slot and a busy/valid handshake.
- Requests are issued to the SCI one per cycle under round-robin priority.
- Read responses are registered and returned only to the issuing master.

Parameters:
- P_RR_ENABLE, 1, 1 = round-robin priority; 0 = fixed priority with master 0 always winning.

Ports:
- iIF_CLOCK  in  1  interface clock
- inRESET  in  1  reset
- iM0_REQ_VALID  in  1  master 0 request strobe
- oM0_REQ_BUSY  out  1  master 0 slot occupied; request not accepted
- iM0_REQ_RW  in  1  1 = write, 0 = read
- iM0_REQ_ADDR  in  2  0 = TX, 1 = RX, 2 = CFG
- iM0_REQ_DATA  in  32  write data
- oM0_REQ_VALID  out  1  read response strobe
- oM0_REQ_DATA  out  32  read response data
- iM1_* / oM1_*: identical set for master 1
- oSCI_REQ_VALID  out  1  issue strobe to SCI
- iSCI_REQ_BUSY  in  1  SCI cannot accept; hold issue
- oSCI_REQ_RW  out  1
- oSCI_REQ_ADDR  out  2
- oSCI_REQ_DATA  out  32
- iSCI_REQ_VALID  in  1  same-cycle read data valid from SCI (RX not empty)
- iSCI_REQ_DATA  in  32  same-cycle read data; bit31 = data present

Interface decision: reset inRESET, asynchronous, active-low; clock iIF_CLOCK.

Behaviour:
Reset values
- All slots empty.
- Round-robin pointer = 0.
- oMx_REQ_BUSY = 0, oMx_REQ_VALID = 0, oMx_REQ_DATA = 0.
- oSCI_REQ_VALID = 0.

Accept
- A request is accepted on a rising edge where iMx_REQ_VALID = 1 and oMx_REQ_BUSY = 0.
- On accept, RW, ADDR and DATA are captured into slot x and pend_x is set.
- oMx_REQ_BUSY = pend_x (registered). A valid presented while busy is ignored; the master must hold it and retry.

Grant (combinational each cycle)
- No pending slot: no grant; oSCI_REQ_VALID = 0, other oSCI outputs = 0.
- One pending slot: that slot wins.
- Both pending: the pointer's master wins. With P_RR_ENABLE = 0, master 0 always wins.

Issue
- oSCI_REQ_VALID = (grant exists) && !iSCI_REQ_BUSY.
- oSCI_REQ_RW / ADDR / DATA come from the granted slot.
- The issue completes at the rising edge where oSCI_REQ_VALID = 1. At that edge:
  - pend of the winner clears.
  - pointer becomes the other master (P_RR_ENABLE = 1 only).
  - For a read, the response register for the winner is loaded.

Read response
- Response data = iSCI_REQ_VALID ? iSCI_REQ_DATA : 32'h0, sampled in the issue cycle.
- oMx_REQ_VALID pulses for exactly one cycle, the cycle after issue. oMx_REQ_DATA holds its value until the next response to that master.
- Writes produce no oMx_REQ_VALID pulse.

Latency and throughput
- Minimum accept-to-response is 2 cycles: accept at edge T, issue in cycle T+1, response visible in cycle T+2.
- A slot can re-accept at the issue edge + 1: busy drops in the cycle after issue.
- Aggregate SCI throughput is 1 request/cycle.

Boundary conditions
- iSCI_REQ_BUSY held high: slots stay pending, pointer frozen, no response.
- Both masters accept in the same edge: both slots fill; the grant is resolved next cycle.
- Reset asserted mid-operation: pending requests are dropped and no response is emitted.
- ADDR = 3 is forwarded unchanged; a read of it returns 0 because the SCI does not respond.

Test Plan:
- Single read: M0 read ADDR 1, SCI returns valid with 0x80000041 → oM0_REQ_VALID = 1 for one cycle, 2 cycles after accept, oM0_REQ_DATA = 0x80000041; oM1_REQ_VALID stays 0.
- Empty read: M1 read ADDR 1 with iSCI_REQ_VALID = 0 → oM1_REQ_VALID pulses, oM1_REQ_DATA = 0x00000000.
- Contention: M0 and M1 both write TX (0x11, 0x22) in the same cycle, pointer = 0 → SCI sees 0x11 then 0x22 on consecutive cycles. Repeat the pair → 0x22 first? No: pointer is now 0 again after two issues, so 0x11 then 0x22. Continuous back-to-back traffic alternates masters strictly.
- Fixed priority (P_RR_ENABLE = 0): both masters continuously valid → M0 is issued every time it is pending; M1 is issued only in cycles where M0's slot is empty.
- SCI busy: iSCI_REQ_BUSY = 1 for 5 cycles with both slots pending → oSCI_REQ_VALID = 0 and both oMx_REQ_BUSY = 1 throughout. Release → two issues on consecutive cycles.
- Reset mid-op: assert inRESET while M0 read is pending → all outputs return to 0 asynchronously, and no response appears after reset deasserts.
